// File: rtl/lcd_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto one HD44780 bus and serialises each transfer into setup/pulse/hold/wait.
// Optional LCD_CLEAR_DELAY_EN: clear/home commands use CLEAR_WAIT_CYCLES in WAIT.
module lcd_bus_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int SETUP_CYCLES      = 4,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 4,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 76000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_enable,
  output logic [7:0]           lcd_data
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_T0  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_T1  = (HOLD_CYCLES > CMD_WAIT_CYCLES) ? HOLD_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_T2  = (MAX_T0 > MAX_T1) ? MAX_T0 : MAX_T1;
  localparam int MAX_ALL = (MAX_T2 > CLEAR_WAIT_CYCLES) ? MAX_T2 : CLEAR_WAIT_CYCLES;
  localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT} state_t;

  state_t             state_r, state_n_s;
  logic [CNT_W-1:0]   cnt_r, cnt_n_s;
  logic [IDX_W-1:0]   ptr_r, lock_owner_r, sel_idx_s;
  logic               lock_valid_r, sel_hit_s, accept_s;
  logic [NUM_REQ-1:0] grant_r;
  logic               lcd_rs_r, lcd_enable_r;
  logic [7:0]         lcd_data_r;
  int                 wait_len_s;

  // Timed stages in order: 0 setup, 1 pulse, 2 hold, 3 wait; anything else is idle.
  function automatic int stage_len(input int stage, input int wait_len);
    case (stage)
      0:       return SETUP_CYCLES;
      1:       return PULSE_CYCLES;
      2:       return HOLD_CYCLES;
      3:       return wait_len;
      default: return 0;
    endcase
  endfunction

  function automatic int stage_of(input state_t st);
    case (st)
      ST_SETUP: return 0;
      ST_PULSE: return 1;
      ST_HOLD:  return 2;
      ST_WAIT:  return 3;
      default:  return 4;
    endcase
  endfunction

  // First non-empty stage at or after 'stage', so zero-length timers are skipped.
  function automatic state_t first_state(input int stage, input int wait_len);
    state_t st;
    st = ST_IDLE;
    for (int k = 3; k >= 0; k--) begin
      if (k >= stage && stage_len(k, wait_len) > 0) st = state_t'(3'(k + 1));
    end
    return st;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_load(input state_t st, input int wait_len);
    int len;
    len = stage_len(stage_of(st), wait_len);
    return (len > 0) ? CNT_W'(len - 1) : '0;
  endfunction

  // Requester selection: lock owner only while locked, otherwise round-robin from ptr_r.
  always_comb begin
    sel_idx_s = '0;
    sel_hit_s = 1'b0;
    if (lock_valid_r) begin
      sel_idx_s = lock_owner_r;
      sel_hit_s = req_valid[lock_owner_r];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
          sel_idx_s = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
          sel_hit_s = 1'b1;
        end else begin
          sel_hit_s = sel_hit_s;
        end
      end
    end
  end

  assign accept_s = (state_r == ST_IDLE) && sel_hit_s;

  // Accept strobe for the selected requester.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[sel_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // WAIT length comes from the request being accepted in IDLE, else from the latched transfer.
`ifdef LCD_CLEAR_DELAY_EN
  logic       eff_rs_s;
  logic [7:0] eff_data_s;
  always_comb begin
    eff_rs_s   = (state_r == ST_IDLE) ? req_rs[sel_idx_s] : lcd_rs_r;
    eff_data_s = (state_r == ST_IDLE) ? req_data[int'(sel_idx_s)*8 +: 8] : lcd_data_r;
    if (!eff_rs_s && (eff_data_s[7:1] == 7'd0)) begin
      wait_len_s = CLEAR_WAIT_CYCLES;
    end else begin
      wait_len_s = CMD_WAIT_CYCLES;
    end
  end
`else
  assign wait_len_s = CMD_WAIT_CYCLES;
`endif

  // Next-state and shared down-counter.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n_s = first_state(0, wait_len_s);
          cnt_n_s   = cnt_load(state_n_s, wait_len_s);
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      default: begin
        if (cnt_r == '0) begin
          state_n_s = first_state(stage_of(state_r) + 1, wait_len_s);
          cnt_n_s   = cnt_load(state_n_s, wait_len_s);
        end else begin
          cnt_n_s = cnt_r - CNT_W'(1);
        end
      end
    endcase
  end

  // State, counter, ownership and latched LCD bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      ptr_r        <= '0;
      lock_valid_r <= 1'b0;
      lock_owner_r <= '0;
      grant_r      <= '0;
      lcd_rs_r     <= 1'b0;
      lcd_data_r   <= 8'h00;
      lcd_enable_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      cnt_r        <= cnt_n_s;
      lcd_enable_r <= (state_n_s == ST_PULSE);
      if (accept_s) begin
        lcd_rs_r     <= req_rs[sel_idx_s];
        lcd_data_r   <= req_data[int'(sel_idx_s)*8 +: 8];
        grant_r      <= NUM_REQ'(1'b1) << sel_idx_s;
        ptr_r        <= IDX_W'((int'(sel_idx_s) + 1) % NUM_REQ);
        lock_valid_r <= req_lock[sel_idx_s];
        lock_owner_r <= sel_idx_s;
      end else if (state_r != ST_IDLE && state_n_s == ST_IDLE && !lock_valid_r) begin
        grant_r <= '0;
      end
    end
  end

  assign grant      = grant_r;
  assign busy       = (state_r != ST_IDLE);
  assign lcd_rs     = lcd_rs_r;
  assign lcd_rw     = 1'b0;
  assign lcd_enable = lcd_enable_r;
  assign lcd_data   = lcd_data_r;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: transaction-level timing model plus directed scenarios.
module tb_lcd_bus_arbiter;

  localparam int N   = 2;
  localparam int S   = 2;
  localparam int P   = 3;
  localparam int H   = 2;
  localparam int W   = 5;
  localparam int CLR = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0, req_lock = '0, req_rs = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready, grant;
  logic           busy, lcd_rs, lcd_rw, lcd_enable;
  logic [7:0]     lcd_data;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc[$];
  int acc_idx[$];

  lcd_bus_arbiter #(
    .NUM_REQ(N), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .CMD_WAIT_CYCLES(W), .CLEAR_WAIT_CYCLES(CLR)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_rs(req_rs), .req_data(req_data), .req_ready(req_ready), .grant(grant),
    .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_enable(lcd_enable),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a transfer is a span of cycles after its accept; m_t counts cycles since accept, 0 when idle.
  int         m_t, m_total, m_ptr, m_owner;
  logic       m_lock, m_rs;
  logic [7:0] m_data;
  logic [N-1:0] m_grant;

  function automatic int m_wait(input logic rs, input logic [7:0] d);
`ifdef LCD_CLEAR_DELAY_EN
    if (!rs && d[7:1] == 7'd0) return CLR;
`endif
    return W;
  endfunction

  function automatic int m_pick();
    if (m_lock) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t <= 0; m_total <= 0; m_ptr <= 0; m_owner <= 0;
      m_lock <= 1'b0; m_rs <= 1'b0; m_data <= 8'h00; m_grant <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_t != 0) begin
        if (m_t == m_total) begin
          m_t <= 0;
          if (!m_lock) m_grant <= '0;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (m_pick() >= 0) begin
        m_t     <= 1;
        m_total <= S + P + H + m_wait(req_rs[m_pick()], req_data[8*m_pick() +: 8]);
        m_grant <= N'(1) << m_pick();
        m_ptr   <= (m_pick() + 1) % N;
        m_lock  <= req_lock[m_pick()];
        m_owner <= m_pick();
        m_rs    <= req_rs[m_pick()];
        m_data  <= req_data[8*m_pick() +: 8];
      end
    end
  end

  // Per-cycle comparison against the model, plus the bus invariants and an accept log.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    exp_ready = '0;
    if (m_t == 0 && m_pick() >= 0) exp_ready = N'(1) << m_pick();
    chk("ready",  req_ready, exp_ready);
    chk("busy",   busy, m_t != 0);
    chk("enable", lcd_enable, (m_t >= S + 1) && (m_t <= S + P));
    chk("grant",  grant, m_grant);
    chk("rs",     lcd_rs, m_rs);
    chk("data",   lcd_data, m_data);
    chk("rw_zero", lcd_rw, 1'b0);
    chk("ready_while_busy", busy && (req_ready != '0), 1'b0);
    chk("ready_onehot", $countones(req_ready) <= 1, 1'b1);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        acc_cyc.push_back(cyc);
        acc_idx.push_back(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    acc_cyc.delete(); acc_idx.delete();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_enable", lcd_enable, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 1'b0);
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int b;
    b = 0;
    while (acc_idx.size() < n && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    chk("accept_timeout", acc_idx.size() >= n, 1'b1);
  endtask

  initial begin
    logic found;
    // Single transfer from requester 0
    do_reset();
    tick();
    req_valid = 2'b01; req_rs = 2'b01; req_data = 16'h0041; req_lock = 2'b00;
    @(negedge clk);
    chk("single_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("single_enable", lcd_enable, (k >= 3 && k <= 5));
      chk("single_busy", busy, (k <= 12));
      chk("single_data", lcd_data, 8'h41);
      chk("single_rs", lcd_rs, 1'b1);
      chk("single_ready", req_ready, 2'b00);
      chk("single_grant", grant, (k <= 12) ? 2'b01 : 2'b00);
      tick();
    end

    // Round-robin without lock
    do_reset();
    tick();
    req_valid = 2'b11; req_lock = 2'b00; req_rs = 2'b11; req_data = 16'h2010;
    wait_accepts(4, 100);
    req_valid = 2'b00;
    if (acc_idx.size() >= 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("rr_order", acc_idx[j], j % 2);
        if (j > 0) chk("rr_spacing", acc_cyc[j] - acc_cyc[j-1], 13);
      end
    end
    repeat (15) tick();

    // Lock burst: CGRAM address then 8 rows while requester 1 keeps asking
    do_reset();
    tick();
    req_valid = 2'b11; req_lock = 2'b01; req_rs = 2'b10; req_data = 16'h8040;
    for (int j = 0; j < 9; j++) begin
      found = 1'b0;
      for (int b = 0; b < 40 && !found; b++) begin
        @(negedge clk);
        if (req_ready[0]) found = 1'b1;
      end
      chk("lock_wait", found, 1'b1);
      chk("lock_ready", req_ready, 2'b01);
      if (j > 0) chk("lock_gap_grant", grant, 2'b01);
      tick();
      req_rs[0] = 1'b1;
      req_data[7:0] = 8'h10 + 8'(j);
      req_lock[0] = (j + 1 < 8);
      if (j == 8) req_valid[0] = 1'b0;
    end
    wait_accepts(10, 40);
    req_valid = 2'b00;
    if (acc_idx.size() >= 10) begin
      for (int j = 0; j < 9; j++) chk("lock_owner_first", acc_idx[j], 0);
      chk("lock_then_req1", acc_idx[9], 1);
    end
    repeat (15) tick();

    // Reset in the middle of the enable pulse
    do_reset();
    tick();
    req_valid = 2'b11; req_lock = 2'b00; req_rs = 2'b11; req_data = 16'h2010;
    wait_accepts(1, 10);
    tick(); tick(); tick();
    chk("mid_enable_high", lcd_enable, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_enable_drop", lcd_enable, 1'b0);
    chk("mid_busy_drop", busy, 1'b0);
    tick();
    reset = 1'b0;
    acc_cyc.delete(); acc_idx.delete();
    wait_accepts(1, 10);
    if (acc_idx.size() >= 1) chk("mid_first_after_reset", acc_idx[0], 0);
    req_valid = 2'b00;
    repeat (15) tick();

    // Clear command wait
    do_reset();
    tick();
    req_valid = 2'b01; req_lock = 2'b00; req_rs = 2'b00; req_data = 16'h0001;
    wait_accepts(2, 80);
    req_valid = 2'b00;
`ifdef LCD_CLEAR_DELAY_EN
    if (acc_cyc.size() >= 2) chk("clear_spacing", acc_cyc[1] - acc_cyc[0], 28);
`else
    if (acc_cyc.size() >= 2) chk("clear_spacing", acc_cyc[1] - acc_cyc[0], 13);
`endif
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single 8-bit HD44780 LCD bus between NUM_REQ requesters. Typical requesters are the CGRAM glyph loader, the text/cursor writer and the init-config sequencer.
- Each accepted transfer of {rs, data} is serialised into a timed enable pulse: setup, pulse, hold, then the controller busy-wait.
- Requesters no longer drive the LCD enable from a divided clock.
- A lock lets one requester keep the bus for multi-byte sequences, e.g. a CGRAM address followed by 8 glyph rows.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- SETUP_CYCLES, 4, clk cycles with rs/data valid and enable low before the pulse.
- PULSE_CYCLES, 12, clk cycles with lcd_enable high.
- HOLD_CYCLES, 4, clk cycles with data held after enable falls.
- CMD_WAIT_CYCLES, 2000, controller execution wait after hold (40 us at 50 MHz).
- CLEAR_WAIT_CYCLES, 76000, wait after clear/home; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_lock  in  NUM_REQ  keep bus ownership after this transfer.
- req_rs  in  NUM_REQ  rs bit per requester.
- req_data  in  8*NUM_REQ  data byte per requester; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  accept strobe; a transfer is taken when req_valid[i] and req_ready[i] are both high.
- grant  out  NUM_REQ  one-hot current owner; 0 when no owner.
- busy  out  1  high whenever the state is not IDLE.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied to 0.
- lcd_enable  out  1  LCD E strobe.
- lcd_data  out  8  LCD data bus.

Behaviour:
- States: IDLE, SETUP, PULSE, HOLD, WAIT. One down-counter is shared by all timed states; width is $clog2 of the largest wait.
- Reset values: state=IDLE, lcd_enable=0, lcd_rs=0, lcd_rw=0, lcd_data=0, grant=0, lock cleared, round-robin pointer=0 (req 0 has highest priority first).
- Reset mid-pulse: lcd_enable drops immediately (asynchronous); any in-flight transfer is discarded.
- IDLE selection when unlocked: the first i with req_valid[i]=1, searching round-robin from pointer.
- IDLE selection when locked: only the lock owner is eligible. Other requests are ignored until release, even when the owner is idle; starvation here is intended.
- req_ready is combinational: req_ready[i] = (state==IDLE) && selected==i && req_valid[i]. At most one bit is high.
- Accept (cycle 0):
  - Register lcd_rs and lcd_data.
  - grant becomes one-hot(i).
  - Pointer becomes (i+1) mod NUM_REQ.
  - If req_lock[i]=1, set lock owner to i. If req_lock[i]=0, the lock is cleared at return to IDLE.
  - Next state is SETUP.
- Timed sequence:
  - SETUP lasts SETUP_CYCLES cycles with enable=0.
  - PULSE lasts PULSE_CYCLES cycles with enable=1.
  - HOLD lasts HOLD_CYCLES cycles with enable=0.
  - WAIT lasts the selected wait count with enable=0.
  - Then IDLE.
  - With defaults, lcd_enable rises at cycle 5 and falls at cycle 17. IDLE is re-entered at cycle S+P+H+W+1 = 2021, and a new accept is possible in that same cycle.
- lcd_rs/lcd_data are stable from SETUP through WAIT. They keep their last value in IDLE.
- grant at return to IDLE: stays one-hot for a locked owner; otherwise goes to 0.
- req_valid may drop at any time outside the accept cycle without effect.
- A timer parameter of 0 skips that state (0 cycles).

Optional Feature:
- Macro: LCD_CLEAR_DELAY_EN.
- Defined: a transfer with rs=0 and data[7:1]==0 (0x01 clear, 0x02/0x03 home) uses CLEAR_WAIT_CYCLES in WAIT.
- Undefined: every transfer uses CMD_WAIT_CYCLES; CLEAR_WAIT_CYCLES is unused.

Test Plan:
- Bench parameters: SETUP=2, PULSE=3, HOLD=2, CMD_WAIT=5, CLEAR_WAIT=20, NUM_REQ=2.
- Single transfer: req 0 sends rs=1, data=0x41 → req_ready[0] pulses one cycle; lcd_enable high cycles 3-5; lcd_data=0x41 and lcd_rs=1 cycles 1-12; IDLE at cycle 13; grant returns to 0.
- Round-robin: both requesters hold valid continuously without lock → accept order 0,1,0,1; each accept is 13 cycles after the previous one.
- Lock burst: req 0 sends 0x40 with lock, then 8 bytes with lock=1 except the last with lock=0, while req 1 stays valid → all 9 req 0 transfers complete before the first req 1 accept; grant[0] is held across IDLE gaps.
- Reset mid-pulse: assert reset in PULSE → lcd_enable=0 and busy=0 in the same cycle; after release, a pending req 1 is not served before req 0, because the pointer resets to 0.
- Clear delay: rs=0, data=0x01 → with LCD_CLEAR_DELAY_EN, next accept at cycle 28; without it, at cycle 13.
- rw/ready invariants: lcd_rw=0 at all times; req_ready is never high while busy=1; at most one req_ready bit is high in any cycle.
